// File: rtl/serial_add_ctrl_pkg.sv
// Shared state encodings, default operand width and counter sizing for the bit-serial adder.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to count 0..w inclusive without wrapping.
  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder shared by the serial adder, built from two half adders and an OR gate.
module serial_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  serial_half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1),  .o_c(w_c1));
  serial_half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_sum), .o_c(w_c2));

  assign o_cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: IDLE/RUN/DONE control around one shared full-adder cell, LSB first.
// Defining SERIAL_ADD_OVF_EN adds the signed-overflow output OVF.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_OVF_EN
  output logic             OVF,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cOut;
  logic [CW-1:0]    r_cnt;
  logic             w_sumBit;
  logic             w_carryOut;
  logic             w_lastBit;
  logic             w_accept;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  serial_fa_cell u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_cin (r_carry),
    .o_sum (w_sumBit),
    .o_cout(w_carryOut)
  );

  assign w_accept  = (r_state == IDLE) && start;
  assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_nextState = RUN;
      end
      RUN: begin
        if (w_lastBit) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result registers are loaded on the final RUN edge so they are already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cOut  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= Cin;
      r_cOut  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == RUN) begin
      r_sum   <= {w_sumBit, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_carryOut;
      r_cnt   <= r_cnt + CW'(1);
      if (w_lastBit) begin
        r_cOut <= w_carryOut;
`ifdef SERIAL_ADD_OVF_EN
        r_ovf  <= r_carry ^ w_carryOut;
`endif
      end
    end
  end

  assign S = r_sum;
  assign C = r_cOut;
`ifdef SERIAL_ADD_OVF_EN
  assign OVF = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=32; honours SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, cin8, ready8, done8, c8;
  logic [7:0]  a8, b8, s8;
  logic        start32, cin32, ready32, done32, c32;
  logic [31:0] a32, b32, s32;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf8, ovf32;
`endif

  int total = 0;
  int bad   = 0;
  logic [33:0] q8[$];
  logic [33:0] q32[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADD_OVF_EN
    .OVF(ovf8),
`endif
    .ready(ready8), .done(done8), .S(s8), .C(c8)
  );

  serial_add_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .Cin(cin32),
`ifdef SERIAL_ADD_OVF_EN
    .OVF(ovf32),
`endif
    .ready(ready32), .done(done32), .S(s32), .C(c32)
  );

  // Reference: packs {signed overflow, carry out, sum masked to w bits}.
  function automatic logic [33:0] refAdd(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input int w);
    logic [32:0] full;
    logic [31:0] mask;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return {ovf, full[w], full[31:0] & mask};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPop8(input string tag);
    logic [33:0] e;
    if (q8.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = q8.pop_front();
      checkOutput(tag, {31'd0, c8, 24'd0, s8}, {31'd0, e[32:0]});
`ifdef SERIAL_ADD_OVF_EN
      checkOutput({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, e[33]});
`endif
    end
  endtask

  task automatic checkPop32(input string tag);
    logic [33:0] e;
    if (q32.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = q32.pop_front();
      checkOutput(tag, {31'd0, c32, s32}, {31'd0, e[32:0]});
`ifdef SERIAL_ADD_OVF_EN
      checkOutput({tag, "_ovf"}, {63'd0, ovf32}, {63'd0, e[33]});
`endif
    end
  endtask

  task automatic waitReady8();
    int n = 0;
    @(negedge clk);
    while (!ready8 && n < 60) begin @(negedge clk); n++; end
    if (!ready8) checkOutput("ready8_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitReady32();
    int n = 0;
    @(negedge clk);
    while (!ready32 && n < 80) begin @(negedge clk); n++; end
    if (!ready32) checkOutput("ready32_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                input string tag);
    int lat;
    waitReady8();
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    q8.push_back(refAdd({24'd0, a}, {24'd0, b}, ci, 8));
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd9);
    checkPop8(tag);
  endtask

  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                 input string tag);
    int lat;
    waitReady32();
    a32 = a; b32 = b; cin32 = ci; start32 = 1'b1;
    q32.push_back(refAdd(a, b, ci, 32));
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 60) begin @(negedge clk); lat++; end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
    checkPop32(tag);
  endtask

  initial begin
    int dones;
    int firstDone;
    int secondDone;
    int doneSeen;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_ready8", {63'd0, ready8}, 64'd1);
    checkOutput("rst_done8",  {63'd0, done8},  64'd0);
    checkOutput("rst_s8",     {56'd0, s8},     64'd0);
    checkOutput("rst_c8",     {63'd0, c8},     64'd0);
    checkOutput("rst_ready32", {63'd0, ready32}, 64'd1);
    checkOutput("rst_s32",     {32'd0, s32},     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic add with handshake timing and a one-cycle done pulse
    waitReady8();
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(refAdd(32'h5A, 32'h3C, 1'b0, 8));
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("busy_ready8", {63'd0, ready8}, 64'd0);
    dones = 1;
    while (!done8 && dones < 40) begin @(negedge clk); dones++; end
    checkOutput("basic_latency", 64'(dones), 64'd9);
    checkPop8("basic_5a_3c");
    @(negedge clk);
    checkOutput("done_one_cycle", {63'd0, done8}, 64'd0);
    checkOutput("idle_ready8",    {63'd0, ready8}, 64'd1);
    checkOutput("hold_s8",        {56'd0, s8},     64'h96);

    applyStimulus8(8'hFF, 8'h01, 1'b0, "carry_out");
    applyStimulus8(8'h7F, 8'h00, 1'b1, "signed_ovf");
    applyStimulus8(8'hFF, 8'hFF, 1'b1, "all_ones");
    applyStimulus8(8'h80, 8'h80, 1'b0, "neg_ovf");

    // start held high; operands change mid-RUN and become the second operation
    waitReady8();
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(refAdd(32'h11, 32'h22, 1'b0, 8));
    dones = 0; firstDone = 0; secondDone = 0;
    for (int n = 1; n <= 40 && dones < 2; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a8 = 8'h40; b8 = 8'h05;
        q8.push_back(refAdd(32'h40, 32'h05, 1'b0, 8));
      end
      if (done8) begin
        dones++;
        checkPop8("held_start");
        if (dones == 1) firstDone = n;
        else begin secondDone = n; start8 = 1'b0; end
      end
    end
    checkOutput("held_done_count", 64'(dones), 64'd2);
    checkOutput("held_done_gap", 64'(secondDone - firstDone), 64'd10);

    // Reset four cycles into RUN aborts with no done pulse
    waitReady8();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ready8", {63'd0, ready8}, 64'd1);
    checkOutput("abort_s8",     {56'd0, s8},     64'd0);
    checkOutput("abort_c8",     {63'd0, c8},     64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    applyStimulus8(8'h01, 8'h01, 1'b0, "after_abort");

    // Random traffic on both widths
    for (int i = 0; i < 1000; i++)
      applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");
    applyStimulus32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap32");
    for (int i = 0; i < 1000; i++)
      applyStimulus32($urandom, $urandom, 1'($urandom_range(0, 1)), "rand32");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
